gfx_draw_engine: RTL and testbench
==================================

GFX_DRAW_ENGINE -- requirements
Module: gfx_draw_engine

Interface
REQ-001 SHALL have parameter XW, default 11, meaning x coordinate/width bits.
REQ-002 SHALL have parameter YW, default 10, meaning y coordinate/height bits.
REQ-003 SHALL have parameter BPP_BYTES, default 4, meaning bytes per pixel; legal values are 1, 2 and 4.
REQ-004 SHALL have parameter ADDR_W, default 32, meaning framebuffer address bits.
REQ-005 SHALL use one clock and a synchronous, active-high reset. The ports are m_axi_aclk (in, 1, clock) and reset (in, 1, synchronous active-high reset).
REQ-006 SHALL have these configuration inputs, sampled at command accept:
  - fb_base_addr (in, ADDR_W)
  - screen_width (in, XW)
  - screen_height (in, YW)
REQ-007 SHALL have these command ports:
  - cmd_valid (in, 1)
  - cmd_ready (out, 1)
  - cmd_op (in, 3)
  - cmd_x0, cmd_x1 (in, XW)
  - cmd_y0, cmd_y1 (in, YW)
  - cmd_color (in, 32)
REQ-008 SHALL have these pixel-write ports, which connect to the AXI master wrapper:
  - px_valid (out, 1)
  - px_ready (in, 1)
  - px_addr (out, ADDR_W)
  - px_data (out, 32), cmd_color zero-extended from its low 8*BPP_BYTES bits
REQ-009 SHALL have these status ports:
  - wr_err (in, 1), write error from the wrapper
  - busy (out, 1)
  - done (out, 1), a one-cycle pulse
  - err (out, 1), sticky
  - px_count (out, XW+YW), pixels accepted for the current or last command

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, RUN and DONE.
REQ-011 SHALL assert cmd_ready only in IDLE. A command is accepted on a cycle where cmd_valid and cmd_ready are both high; that cycle moves the FSM to SETUP and clears err and px_count.
REQ-012 SHALL decode cmd_op as follows:
  - 0 NOP
  - 1 FILL_RECT
  - 2 OUTLINE_RECT
  - 3 HLINE (row y0, columns x0..x1)
  - 4 VLINE (column x0, rows y0..y1)
  - 5 CLEAR (the full screen)
  - 6 and 7 are illegal
REQ-013 SETUP SHALL take one cycle, in which it:
  - swaps x0/x1 if x0>x1 and y0/y1 if y0>y1;
  - clamps x1 to screen_width-1 and y1 to screen_height-1;
  - computes the first-pixel address.
REQ-014 SHALL go from SETUP directly to DONE, with zero pixels emitted, for any of: NOP, an illegal op, x0>=screen_width, y0>=screen_height, or screen_width==0 or screen_height==0.
REQ-015 An illegal op SHALL additionally set err.
REQ-016 SHALL emit pixels in row-major order, x increasing within a row and then y increasing.
REQ-017 For OUTLINE_RECT, rows strictly between y0 and y1 SHALL emit only x0 and x1, with the scan jumping from x0 to x1 with no idle cycle. A degenerate rectangle (x0==x1 or y0==y1) SHALL emit each pixel exactly once.
REQ-018 SHALL compute px_addr = fb_base_addr + (y*screen_width + x)*BPP_BYTES incrementally, with no multiplier in RUN:
  - add BPP_BYTES per x step;
  - maintain a row-base register that advances by screen_width*BPP_BYTES per row, that product being formed once in SETUP.
REQ-019 SHALL perform address arithmetic modulo 2^ADDR_W, with no overflow detection.
REQ-020 SHALL raise px_valid in the first RUN cycle, i.e. accept cycle + 2.
REQ-021 While px_valid is high and px_ready is low, px_addr and px_data SHALL hold stable.
REQ-022 A pixel SHALL be accepted on a cycle where px_valid and px_ready are both high. On acceptance, px_count increments and the next pixel is presented in the next cycle, sustaining 1 pixel per clock.
REQ-023 After the last pixel is accepted, the FSM SHALL enter DONE. DONE lasts one cycle, asserts done, and returns to IDLE.
REQ-024 busy SHALL be high in SETUP, RUN and DONE.
REQ-025 A wr_err sampled high in RUN SHALL:
  - set err;
  - deassert px_valid on the next cycle;
  - enter DONE.
REQ-026 If px_ready and wr_err are high in the same cycle, that pixel SHALL count as accepted before the abort.
REQ-027 SHALL ignore wr_err outside RUN.
REQ-028 err SHALL hold until the next command is accepted.
REQ-029 cmd_* inputs SHALL be don't-care outside the accept cycle; the block registers them on acceptance.

Reset
REQ-030 reset high at a clock edge SHALL force state IDLE from any state, including mid-RUN, with any in-flight pixel dropped and no done pulse.
REQ-031 Output values while reset is high and on the first cycle after it SHALL be:
  - cmd_ready 1
  - px_valid 0
  - px_addr 0
  - px_data 0
  - busy 0
  - done 0
  - err 0
  - px_count 0

Structure
REQ-032 The shared package gfx_pkg SHALL hold the op-code constants (GFX_OP_NOP through GFX_OP_CLEAR) and the FSM state enum.
REQ-033 SHALL place coordinate normalisation, clipping and the scan/address stepping in one sub-module, gfx_scan_gen. The top level holds the FSM, the handshake and the status logic.
REQ-034 SHALL contain no multiplier outside the SETUP product in REQ-018.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - FILL_RECT (2,1)-(4,2), base 0x1000_0000, width 640, BPP 4, px_ready constant 1 -> 6 pixels on consecutive cycles at 0x1000_0A08, 0A0C, 0A10, 0A58…? **No:** expected addresses are base+4*(640*y+x), i.e. 0x1000_0A08, 0x1000_0A0C, 0x1000_0A10, 0x1000_1408, 0x1000_140C, 0x1000_1410; done at the cycle after the last acceptance; px_count 6.
  - OUTLINE_RECT (0,0)-(3,3) -> 12 pixels; rows 1-2 emit x=0 and x=3 only.
  - HLINE with x0=630, x1=700, y0=5, width 640 -> clipped to x 630..639, 10 pixels. VLINE with x0=800 -> zero pixels, done at accept+2.
  - px_ready toggling on alternate cycles during FILL_RECT -> px_addr/px_data stable while stalled; no pixel lost or duplicated.
  - wr_err on the same cycle as the 3rd acceptance -> px_count 3, err 1, done pulses once, px_valid low the next cycle.
  - Reset asserted mid-RUN -> next cycle IDLE with cmd_ready 1, px_valid 0, no done pulse. Op 7 -> err 1, 0 pixels.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared definitions for the draw engine: op codes, FSM states and the
// bytes-per-pixel shift helper.
package gfx_pkg;

    localparam logic [2:0] GFX_OP_NOP          = 3'd0;
    localparam logic [2:0] GFX_OP_FILL_RECT    = 3'd1;
    localparam logic [2:0] GFX_OP_OUTLINE_RECT = 3'd2;
    localparam logic [2:0] GFX_OP_HLINE        = 3'd3;
    localparam logic [2:0] GFX_OP_VLINE        = 3'd4;
    localparam logic [2:0] GFX_OP_CLEAR        = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } gfx_state_e;

    // BPP_BYTES is restricted to powers of two, so scaling is a shift.
    function automatic int bpp_shift(input int bpp);
        return (bpp == 4) ? 2 : ((bpp == 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/gfx_scan_gen.sv
// Coordinate normalisation, clipping and row-major scan with incremental
// framebuffer address stepping for the draw engine.
module gfx_scan_gen
    import gfx_pkg::*;
#(
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int BPP_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [2:0]        op,
    input  logic [XW-1:0]     x0,
    input  logic [XW-1:0]     x1,
    input  logic [YW-1:0]     y0,
    input  logic [YW-1:0]     y1,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [XW-1:0]     screen_width,
    input  logic [YW-1:0]     screen_height,
    output logic              empty,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam int SHIFT = bpp_shift(BPP_BYTES);

    logic [XW-1:0]     ax0, ax1, nx_lo, nx_hi, w_max;
    logic [YW-1:0]     ay0, ay1, ny_lo, ny_hi, h_max;
    logic [ADDR_W-1:0] stride, first_addr, span;

    logic [XW-1:0]     cur_x, x_lo, x_hi;
    logic [YW-1:0]     cur_y, y_lo, y_hi;
    logic              outline;
    logic [ADDR_W-1:0] stride_q, span_q, row_base;
    logic              jump;

    always_comb begin
        ax0   = x0;
        ax1   = x1;
        ay0   = y0;
        ay1   = y1;
        w_max = screen_width - XW'(1);
        h_max = screen_height - YW'(1);
        case (op)
            GFX_OP_HLINE: ay1 = y0;
            GFX_OP_VLINE: ax1 = x0;
            GFX_OP_CLEAR: begin
                ax0 = '0;
                ax1 = w_max;
                ay0 = '0;
                ay1 = h_max;
            end
            default: ;
        endcase
        nx_lo = (ax0 > ax1) ? ax1 : ax0;
        nx_hi = (ax0 > ax1) ? ax0 : ax1;
        ny_lo = (ay0 > ay1) ? ay1 : ay0;
        ny_hi = (ay0 > ay1) ? ay0 : ay1;
        if (nx_hi > w_max) nx_hi = w_max;
        if (ny_hi > h_max) ny_hi = h_max;
        empty = (screen_width == '0) || (screen_height == '0) ||
                (nx_lo >= screen_width) || (ny_lo >= screen_height);
        // The only multiply in the block: first row offset, evaluated once.
        stride     = ADDR_W'(screen_width) << SHIFT;
        first_addr = fb_base + ADDR_W'(ny_lo) * stride + (ADDR_W'(nx_lo) << SHIFT);
        span       = ADDR_W'(nx_hi - nx_lo) << SHIFT;
    end

    assign last = (cur_x == x_hi) && (cur_y == y_hi);
    // Interior outline rows skip straight from the left edge to the right edge.
    assign jump = outline && (cur_y != y_lo) && (cur_y != y_hi) &&
                  (cur_x == x_lo) && (x_lo != x_hi);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x    <= '0;
            cur_y    <= '0;
            x_lo     <= '0;
            x_hi     <= '0;
            y_lo     <= '0;
            y_hi     <= '0;
            outline  <= 1'b0;
            stride_q <= '0;
            span_q   <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            cur_x    <= nx_lo;
            cur_y    <= ny_lo;
            x_lo     <= nx_lo;
            x_hi     <= nx_hi;
            y_lo     <= ny_lo;
            y_hi     <= ny_hi;
            outline  <= (op == GFX_OP_OUTLINE_RECT);
            stride_q <= stride;
            span_q   <= span;
            row_base <= first_addr;
            addr     <= first_addr;
        end else if (step && !last) begin
            if (jump) begin
                cur_x <= x_hi;
                addr  <= addr + span_q;
            end else if (cur_x != x_hi) begin
                cur_x <= cur_x + XW'(1);
                addr  <= addr + ADDR_W'(BPP_BYTES);
            end else begin
                cur_x    <= x_lo;
                cur_y    <= cur_y + YW'(1);
                row_base <= row_base + stride_q;
                addr     <= row_base + stride_q;
            end
        end
    end

endmodule

// File: rtl/gfx_draw_engine.sv
// 2D draw engine top: command handshake, IDLE/SETUP/RUN/DONE sequencing and
// status; pixel scanning lives in gfx_scan_gen.
module gfx_draw_engine
    import gfx_pkg::*;
#(
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int BPP_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                m_axi_aclk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   fb_base_addr,
    input  logic [XW-1:0]       screen_width,
    input  logic [YW-1:0]       screen_height,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [XW-1:0]       cmd_x0,
    input  logic [XW-1:0]       cmd_x1,
    input  logic [YW-1:0]       cmd_y0,
    input  logic [YW-1:0]       cmd_y1,
    input  logic [31:0]         cmd_color,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [ADDR_W-1:0]   px_addr,
    output logic [31:0]         px_data,
    input  logic                wr_err,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [XW+YW-1:0]    px_count
);

    localparam int CNT_W = XW + YW;
    localparam logic [31:0] DATA_MASK = (BPP_BYTES == 4) ? 32'hFFFF_FFFF :
                                        (BPP_BYTES == 2) ? 32'h0000_FFFF : 32'h0000_00FF;

    gfx_state_e        state;
    logic [2:0]        op_q;
    logic [XW-1:0]     x0_q, x1_q, w_q;
    logic [YW-1:0]     y0_q, y1_q, h_q;
    logic [ADDR_W-1:0] base_q;
    logic              scan_empty, scan_last;
    logic              op_illegal;

    assign cmd_ready  = (state == ST_IDLE);
    assign px_valid   = (state == ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign op_illegal = (op_q > GFX_OP_CLEAR);

    gfx_scan_gen #(
        .XW(XW), .YW(YW), .BPP_BYTES(BPP_BYTES), .ADDR_W(ADDR_W)
    ) u_scan (
        .clk           (m_axi_aclk),
        .reset         (reset),
        .load          (state == ST_SETUP),
        .step          ((state == ST_RUN) && px_ready),
        .op            (op_q),
        .x0            (x0_q),
        .x1            (x1_q),
        .y0            (y0_q),
        .y1            (y1_q),
        .fb_base       (base_q),
        .screen_width  (w_q),
        .screen_height (h_q),
        .empty         (scan_empty),
        .last          (scan_last),
        .addr          (px_addr)
    );

    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            base_q   <= '0;
            px_data  <= '0;
            err      <= 1'b0;
            px_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        x0_q     <= cmd_x0;
                        x1_q     <= cmd_x1;
                        y0_q     <= cmd_y0;
                        y1_q     <= cmd_y1;
                        w_q      <= screen_width;
                        h_q      <= screen_height;
                        base_q   <= fb_base_addr;
                        px_data  <= cmd_color & DATA_MASK;
                        err      <= 1'b0;
                        px_count <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if ((op_q == GFX_OP_NOP) || op_illegal || scan_empty) begin
                        err   <= op_illegal;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A pixel accepted alongside wr_err still counts.
                    if (px_ready) begin
                        px_count <= px_count + CNT_W'(1);
                        if (scan_last) state <= ST_DONE;
                    end
                    if (wr_err) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_draw_engine.sv
// Self-checking bench for gfx_draw_engine: directed vector table, reset
// sequences and randomized commands against a loop-based pixel model.
module tb_gfx_draw_engine;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int AW = 32;

    logic          m_axi_aclk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] fb_base_addr = '0;
    logic [XW-1:0] screen_width = '0;
    logic [YW-1:0] screen_height = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [XW-1:0] cmd_x0 = '0, cmd_x1 = '0;
    logic [YW-1:0] cmd_y0 = '0, cmd_y1 = '0;
    logic [31:0]   cmd_color = '0;
    logic          px_valid;
    logic          px_ready = 1'b0;
    logic [AW-1:0] px_addr;
    logic [31:0]   px_data;
    logic          wr_err = 1'b0;
    logic          busy, done, err;
    logic [XW+YW-1:0] px_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        int          x0, x1, y0, y1, w, h;
        logic [31:0] base, color;
        int          rmode, err_at, exp_n;
        logic        exp_err, chk_first;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[13];

    gfx_draw_engine dut (
        .m_axi_aclk(m_axi_aclk), .reset(reset), .fb_base_addr(fb_base_addr),
        .screen_width(screen_width), .screen_height(screen_height),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .px_valid(px_valid), .px_ready(px_ready),
        .px_addr(px_addr), .px_data(px_data), .wr_err(wr_err), .busy(busy),
        .done(done), .err(err), .px_count(px_count)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_px_valid"}, px_valid, 0);
        check({tag, "_px_addr"}, px_addr, 0);
        check({tag, "_px_data"}, px_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_px_count"}, px_count, 0);
    endtask

    // Reference: enumerate the drawn pixel set row by row with plain arithmetic.
    task automatic build_exp(input vec_t v);
        int xl, xh, yl, yh, t;
        exp_q.delete();
        if (v.op == 3'd0 || v.op > 3'd5) return;
        xl = v.x0; xh = v.x1; yl = v.y0; yh = v.y1;
        if (v.op == 3'd3) yh = yl;
        if (v.op == 3'd4) xh = xl;
        if (v.op == 3'd5) begin xl = 0; xh = v.w - 1; yl = 0; yh = v.h - 1; end
        if (xl > xh) begin t = xl; xl = xh; xh = t; end
        if (yl > yh) begin t = yl; yl = yh; yh = t; end
        if (v.w == 0 || v.h == 0 || xl >= v.w || yl >= v.h) return;
        if (xh > v.w - 1) xh = v.w - 1;
        if (yh > v.h - 1) yh = v.h - 1;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                if (v.op == 3'd2 && y != yl && y != yh && x != xl && x != xh) continue;
                exp_q.push_back(v.base + 32'(4 * (v.w * y + x)));
            end
    endtask

    task automatic run_vec(input vec_t v);
        int k, n, first_k, done_k, last_k, done_cnt, exp_n;
        bit stall, fin;
        logic [31:0] held_a, held_d, first_a, ea;
        build_exp(v);
        exp_n = (v.exp_n < 0) ? exp_q.size() : v.exp_n;
        cmd_op = v.op;
        cmd_x0 = v.x0[XW-1:0]; cmd_x1 = v.x1[XW-1:0];
        cmd_y0 = v.y0[YW-1:0]; cmd_y1 = v.y1[YW-1:0];
        cmd_color = v.color;
        fb_base_addr = v.base;
        screen_width = v.w[XW-1:0];
        screen_height = v.h[YW-1:0];
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge m_axi_aclk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_x0 = XW'($urandom); cmd_x1 = XW'($urandom);
        cmd_y0 = YW'($urandom); cmd_y1 = YW'($urandom); cmd_color = $urandom;
        k = 1; n = 0; first_k = -1; done_k = -1; last_k = -1; done_cnt = 0;
        stall = 0; fin = 0; held_a = '0; held_d = '0; first_a = '0;
        while (!fin && k < 4000) begin
            if (k == 1) begin
                check("setup_busy", busy, 1);
                check("setup_px_valid", px_valid, 0);
            end
            wr_err = (k == 1);
            case (v.rmode)
                0: px_ready = 1'b1;
                1: px_ready = (k % 2 == 0);
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            if (px_valid) begin
                if (first_k < 0) first_k = k;
                if (stall) begin
                    check("stall_addr", px_addr, held_a);
                    check("stall_data", px_data, held_d);
                end
                if (px_ready) begin
                    n++;
                    last_k = k;
                    if (n == 1) first_a = px_addr;
                    if (n == v.err_at) wr_err = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_pixel act=%0h exp=none", px_addr);
                    end else begin
                        ea = exp_q.pop_front();
                        check("px_addr", px_addr, ea);
                        check("px_data", px_data, v.color);
                    end
                end
                stall = !px_ready;
                held_a = px_addr;
                held_d = px_data;
            end else begin
                stall = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    check("done_px_valid", px_valid, 0);
                    check("px_count", px_count, exp_n);
                    check("err_at_done", err, v.exp_err);
                end
            end
            if (done_k >= 0 && k == done_k + 1) begin
                check("done_once", done_cnt, 1);
                check("cmd_ready_after", cmd_ready, 1);
                check("busy_after", busy, 0);
                check("err_sticky", err, v.exp_err);
                fin = 1;
            end
            @(negedge m_axi_aclk);
            k++;
        end
        wr_err = 1'b0;
        px_ready = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL cmd_timeout act=%0d exp=done", k);
        end
        check("pixel_total", n, exp_n);
        if (exp_n > 0) begin
            check("first_valid_cycle", first_k, 2);
            check("done_after_last", done_k, last_k + 1);
            if (v.chk_first) check("first_addr", first_a, v.exp_first);
        end else begin
            check("empty_done_cycle", done_k, 2);
            check("empty_no_valid", first_k < 0, 1);
        end
    endtask

    initial begin
        int dcnt;
        vec_t rv;
        //        op   x0   x1   y0  y1   w    h    base          color         rm ea  n  err fchk first
        vecs[0]  = '{3'd1, 2,   4,   1,  2,   640, 480, 32'h1000_0000, 32'hAABB_CCDD, 0, 0, 6,  1'b0, 1'b1, 32'h1000_0A08};
        vecs[1]  = '{3'd2, 0,   3,   0,  3,   16,  16,  32'h2000_0000, 32'h1234_5678, 0, 0, 12, 1'b0, 1'b1, 32'h2000_0000};
        vecs[2]  = '{3'd3, 630, 700, 5,  9,   640, 480, 32'h0000_0000, 32'h0F0F_0F0F, 0, 0, 10, 1'b0, 1'b1, 32'h0000_3BD8};
        vecs[3]  = '{3'd4, 800, 10,  0,  5,   640, 480, 32'h0000_0000, 32'h1111_1111, 0, 0, 0,  1'b0, 1'b0, 32'h0};
        vecs[4]  = '{3'd1, 5,   1,   3,  0,   32,  8,   32'h0000_0100, 32'hCAFE_F00D, 1, 0, 20, 1'b0, 1'b1, 32'h0000_0104};
        vecs[5]  = '{3'd1, 0,   3,   0,  3,   8,   8,   32'h0000_0000, 32'h5555_AAAA, 0, 3, 3,  1'b1, 1'b1, 32'h0};
        vecs[6]  = '{3'd7, 0,   3,   0,  3,   8,   8,   32'h0000_0000, 32'h0,         0, 0, 0,  1'b1, 1'b0, 32'h0};
        vecs[7]  = '{3'd5, 9,   1,   7,  2,   4,   3,   32'h0000_0040, 32'hDEAD_BEEF, 2, 0, 12, 1'b0, 1'b1, 32'h0000_0040};
        vecs[8]  = '{3'd2, 2,   2,   1,  4,   16,  16,  32'h0000_0000, 32'h7777_0000, 0, 0, 4,  1'b0, 1'b1, 32'h0000_0048};
        vecs[9]  = '{3'd0, 0,   3,   0,  3,   16,  16,  32'h0000_0000, 32'h1,         0, 0, 0,  1'b0, 1'b0, 32'h0};
        vecs[10] = '{3'd2, 1,   5,   2,  2,   16,  16,  32'h0000_0000, 32'h2,         0, 0, 5,  1'b0, 1'b1, 32'h0000_0084};
        vecs[11] = '{3'd1, 0,   2,   10, 12,  16,  8,   32'h0000_0000, 32'h3,         0, 0, 0,  1'b0, 1'b0, 32'h0};
        vecs[12] = '{3'd1, 0,   2,   0,  2,   0,   0,   32'h0000_0000, 32'h4,         0, 0, 0,  1'b0, 1'b0, 32'h0};

        reset = 1'b1;
        repeat (3) @(negedge m_axi_aclk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        @(negedge m_axi_aclk);
        check_reset_outputs("after_reset");

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset in the middle of a fill: pixel flow stops, no done pulse follows.
        cmd_op = 3'd1; cmd_x0 = 0; cmd_x1 = 7; cmd_y0 = 0; cmd_y1 = 7;
        screen_width = 16; screen_height = 16; fb_base_addr = 32'h3000;
        cmd_color = 32'h9999_9999; cmd_valid = 1'b1; px_ready = 1'b1;
        @(negedge m_axi_aclk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge m_axi_aclk);
        check("pre_reset_valid", px_valid, 1);
        reset = 1'b1;
        @(negedge m_axi_aclk);
        check_reset_outputs("mid_run_reset");
        reset = 1'b0;
        dcnt = 0;
        repeat (4) begin
            @(negedge m_axi_aclk);
            if (done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);
        check("idle_after_reset", cmd_ready, 1);
        check("no_valid_after_reset", px_valid, 0);
        px_ready = 1'b0;

        for (int i = 0; i < 30; i++) begin
            rv.op = 3'($urandom_range(0, 7));
            rv.w = $urandom_range(1, 24);
            rv.h = $urandom_range(1, 12);
            rv.x0 = $urandom_range(0, 30);
            rv.x1 = $urandom_range(0, 30);
            rv.y0 = $urandom_range(0, 15);
            rv.y1 = $urandom_range(0, 15);
            rv.base = $urandom & 32'hFFFF_FFFC;
            rv.color = $urandom;
            rv.rmode = 2;
            rv.err_at = 0;
            rv.exp_n = -1;
            rv.exp_err = (rv.op > 3'd5);
            rv.chk_first = 1'b0;
            rv.exp_first = '0;
            run_vec(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
